// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron bank.
package lif_pkg;

   localparam int W_DEF      = 8;
   localparam int REFR_W_DEF = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } fsm_state_t;

   localparam logic RESET_TO_CURRENT = 1'b0;
   localparam logic RESET_SUBTRACT   = 1'b1;

   // Unsigned add clamped to 2^w-1; operands must already fit in w bits.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] sum_s;
      logic [32:0] max_s;
      sum_s = {1'b0, a} + {1'b0, b};
      max_s = (33'd1 << w) - 33'd1;
      if (sum_s > max_s) begin
         return max_s[31:0];
      end else begin
         return sum_s[31:0];
      end
   endfunction

endpackage

// File: rtl/lif_array_if.sv
// Input, configuration and result signals of the neuron bank.
interface lif_array_if #(
   parameter int W         = 8,
   parameter int N_NEURONS = 4,
   parameter int REFR_W    = 4,
   parameter int IDX_W     = $clog2(N_NEURONS)
);
   logic              in_valid;
   logic              in_ready;
   logic [IDX_W-1:0]  in_idx;
   logic [W-1:0]      in_current;
   logic [W-1:0]      cfg_threshold;
   logic [2:0]        cfg_decay_shift;
   logic [REFR_W-1:0] cfg_refractory;
   logic              cfg_reset_sub;
   logic              clr_req;
   logic              out_valid;
   logic [IDX_W-1:0]  out_idx;
   logic              out_spike;
   logic [W-1:0]      out_state;

   modport master (
      output in_valid, in_idx, in_current, cfg_threshold, cfg_decay_shift,
             cfg_refractory, cfg_reset_sub, clr_req,
      input  in_ready, out_valid, out_idx, out_spike, out_state
   );

   modport slave (
      input  in_valid, in_idx, in_current, cfg_threshold, cfg_decay_shift,
             cfg_refractory, cfg_reset_sub, clr_req,
      output in_ready, out_valid, out_idx, out_spike, out_state
   );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: leak, integrate, fire, refractory.
module lif_update
   import lif_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int REFR_W = REFR_W_DEF
) (
   input  logic [W-1:0]      s,
   input  logic [REFR_W-1:0] r,
   input  logic [W-1:0]      cur,
   input  logic [W-1:0]      threshold,
   input  logic [2:0]        decay_shift,
   input  logic [REFR_W-1:0] refractory,
   input  logic              reset_sub,
   output logic [W-1:0]      s_next,
   output logic [REFR_W-1:0] r_next,
   output logic              spike
);

   function automatic logic [W-1:0] leak(input logic [W-1:0] v, input logic [2:0] sh);
      if (32'(sh) >= W) begin
         return {W{1'b0}};
      end else begin
         return v >> sh;
      end
   endfunction

   // Refractory check first; spike decision uses the stored pre-update state.
   always_comb begin
      s_next = {W{1'b0}};
      r_next = {REFR_W{1'b0}};
      spike  = 1'b0;
      if (r != {REFR_W{1'b0}}) begin
         r_next = r - REFR_W'(1);
      end else if (s >= threshold) begin
         spike  = 1'b1;
         r_next = refractory;
         if (reset_sub == RESET_SUBTRACT) begin
            s_next = W'(sat_add(32'(cur), 32'(leak(s - threshold, decay_shift)), W));
         end else begin
            s_next = cur;
         end
      end else begin
         s_next = W'(sat_add(32'(cur), 32'(leak(s, decay_shift)), W));
      end
   end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed bank of leaky integrate-and-fire neurons with a clear sweep.
module lif_array
   import lif_pkg::*;
#(
   parameter int W         = W_DEF,
   parameter int N_NEURONS = 4,
   parameter int REFR_W    = REFR_W_DEF,
   parameter int IDX_W     = $clog2(N_NEURONS)
) (
   input logic        clk,
   input logic        rst_n,
   lif_array_if.slave bus
);

   logic [W-1:0]      state_r [N_NEURONS];
   logic [REFR_W-1:0] refr_r  [N_NEURONS];
   fsm_state_t        fsm_r;
   fsm_state_t        fsm_next_s;
   logic [IDX_W-1:0]  clr_idx_r;

   logic              accept_s;
   logic              idx_ok_s;
   logic              wr_en_s;
   logic [W-1:0]      cur_state_s;
   logic [REFR_W-1:0] cur_refr_s;
   logic [W-1:0]      new_state_s;
   logic [REFR_W-1:0] new_refr_s;
   logic              spike_s;

   logic              out_valid_r;
   logic [IDX_W-1:0]  out_idx_r;
   logic              out_spike_r;
   logic [W-1:0]      out_state_r;

   generate
      if ((2 ** IDX_W) == N_NEURONS) begin : g_full_idx
         assign idx_ok_s = 1'b1;
      end else begin : g_part_idx
         assign idx_ok_s = ({1'b0, bus.in_idx} < (IDX_W+1)'(N_NEURONS));
      end
   endgenerate

   assign bus.in_ready = (fsm_r == ST_IDLE);
   assign accept_s     = bus.in_valid & bus.in_ready;
   assign wr_en_s      = accept_s & idx_ok_s;

   // Read the addressed neuron; out-of-range indices read as zero.
   always_comb begin
      cur_state_s = {W{1'b0}};
      cur_refr_s  = {REFR_W{1'b0}};
      if (idx_ok_s) begin
         cur_state_s = state_r[bus.in_idx];
         cur_refr_s  = refr_r[bus.in_idx];
      end else begin
         cur_state_s = {W{1'b0}};
         cur_refr_s  = {REFR_W{1'b0}};
      end
   end

   lif_update #(.W(W), .REFR_W(REFR_W)) u_update (
      .s           (cur_state_s),
      .r           (cur_refr_s),
      .cur         (bus.in_current),
      .threshold   (bus.cfg_threshold),
      .decay_shift (bus.cfg_decay_shift),
      .refractory  (bus.cfg_refractory),
      .reset_sub   (bus.cfg_reset_sub),
      .s_next      (new_state_s),
      .r_next      (new_refr_s),
      .spike       (spike_s)
   );

   // Clear FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_r <= ST_IDLE;
      end else begin
         fsm_r <= fsm_next_s;
      end
   end

   // Clear FSM next-state: one neuron cleared per CLEAR cycle.
   always_comb begin
      fsm_next_s = fsm_r;
      case (fsm_r)
         ST_IDLE: begin
            if (bus.clr_req) begin
               fsm_next_s = ST_CLEAR;
            end else begin
               fsm_next_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (clr_idx_r == IDX_W'(N_NEURONS - 1)) begin
               fsm_next_s = ST_IDLE;
            end else begin
               fsm_next_s = ST_CLEAR;
            end
         end
         default: fsm_next_s = ST_IDLE;
      endcase
   end

   // Sweep pointer: parked at 0 while idle, advances through the bank in CLEAR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_idx_r <= {IDX_W{1'b0}};
      end else if (fsm_r == ST_CLEAR) begin
         clr_idx_r <= clr_idx_r + IDX_W'(1);
      end else begin
         clr_idx_r <= {IDX_W{1'b0}};
      end
   end

   // Membrane and refractory arrays; sweep and updates never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            state_r[k] <= {W{1'b0}};
            refr_r[k]  <= {REFR_W{1'b0}};
         end
      end else begin
         for (int k = 0; k < N_NEURONS; k++) begin
            if ((fsm_r == ST_CLEAR) && (clr_idx_r == IDX_W'(k))) begin
               state_r[k] <= {W{1'b0}};
               refr_r[k]  <= {REFR_W{1'b0}};
            end else if (wr_en_s && (bus.in_idx == IDX_W'(k))) begin
               state_r[k] <= new_state_s;
               refr_r[k]  <= new_refr_s;
            end
         end
      end
   end

   // Result register, valid for one cycle after each in-range accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_idx_r   <= {IDX_W{1'b0}};
         out_spike_r <= 1'b0;
         out_state_r <= {W{1'b0}};
      end else begin
         out_valid_r <= wr_en_s;
         if (wr_en_s) begin
            out_idx_r   <= bus.in_idx;
            out_spike_r <= spike_s;
            out_state_r <= new_state_s;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.out_spike = out_spike_r;
   assign bus.out_state = out_state_r;

endmodule

// File: tb/tb_lif_array.sv
// Scoreboard bench for lif_array: directed scenarios plus randomized updates against a reference model.
module tb_lif_array;

   localparam int W      = 8;
   localparam int N      = 4;
   localparam int REFR_W = 4;
   localparam int MAXV   = (1 << W) - 1;

   logic clk;
   logic rst_n;

   lif_array_if #(.W(W), .N_NEURONS(N), .REFR_W(REFR_W)) bus ();

   lif_array #(.W(W), .N_NEURONS(N), .REFR_W(REFR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int idx;
      int spike;
      int state;
   } exp_t;

   exp_t sb[$];
   int   m_s[N];
   int   m_r[N];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > MAXV) ? MAXV : x;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         m_s[i] = 0;
         m_r[i] = 0;
      end
   endfunction

   // Monitor: every DUT result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_idx", int'(bus.out_idx), e.idx);
            chk("out_spike", int'(bus.out_spike), e.spike);
            chk("out_state", int'(bus.out_state), e.state);
         end
      end
   end

   task automatic wait_sweep();
      int low;
      low = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.in_ready) break;
         low++;
         @(posedge clk);
         #1;
      end
      chk("clear_ready_low_cycles", low, N);
   endtask

   // One accepted update (optionally with clr_req in the same cycle).
   task automatic issue(input int idx, input int cur, input int thr, input int sh,
                        input int refr, input int sub, input bit clr);
      int ns;
      int sp;
      exp_t e;
      chk("in_ready_before_issue", int'(bus.in_ready), 1);
      bus.in_valid        = 1'b1;
      bus.in_idx          = 2'(idx);
      bus.in_current      = 8'(cur);
      bus.cfg_threshold   = 8'(thr);
      bus.cfg_decay_shift = 3'(sh);
      bus.cfg_refractory  = 4'(refr);
      bus.cfg_reset_sub   = sub[0];
      bus.clr_req         = clr;
      sp = 0;
      if (m_r[idx] != 0) begin
         ns = 0;
         m_r[idx] = m_r[idx] - 1;
      end else if (m_s[idx] >= thr) begin
         sp = 1;
         m_r[idx] = refr;
         ns = (sub != 0) ? sat(cur + ((m_s[idx] - thr) >> sh)) : cur;
      end else begin
         ns = sat(cur + (m_s[idx] >> sh));
      end
      m_s[idx] = ns;
      e.idx = idx;
      e.spike = sp;
      e.state = ns;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.clr_req  = 1'b0;
      if (clr) begin
         model_clear();
         wait_sweep();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid        = 1'b0;
      bus.in_idx          = '0;
      bus.in_current      = '0;
      bus.cfg_threshold   = '0;
      bus.cfg_decay_shift = '0;
      bus.cfg_refractory  = '0;
      bus.cfg_reset_sub   = 1'b0;
      bus.clr_req         = 1'b0;
      model_clear();
      rst_n = 1'b0;
      #3;
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_in_ready", int'(bus.in_ready), 1);
      chk("reset_out_state", int'(bus.out_state), 0);
      chk("reset_out_idx", int'(bus.out_idx), 0);
      chk("reset_out_spike", int'(bus.out_spike), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Integrate then fire (reset-to-current).
      issue(0, 100, 127, 1, 0, 0, 1'b0);
      issue(0, 100, 127, 1, 0, 0, 1'b0);
      issue(0, 10, 127, 1, 0, 0, 1'b0);
      // Saturation, then spike from the clamped state.
      issue(1, 200, 255, 1, 0, 0, 1'b0);
      issue(1, 250, 255, 1, 0, 0, 1'b0);
      issue(1, 5, 127, 1, 0, 0, 1'b0);
      // Refractory period of two updates.
      issue(2, 200, 255, 1, 0, 0, 1'b0);
      issue(2, 200, 127, 1, 2, 0, 1'b0);
      issue(2, 200, 127, 1, 2, 0, 1'b0);
      issue(2, 200, 127, 1, 2, 0, 1'b0);
      issue(2, 200, 255, 1, 2, 0, 1'b0);
      // Reset by subtraction.
      issue(3, 150, 255, 1, 0, 1, 1'b0);
      issue(3, 20, 127, 1, 0, 1, 1'b0);
      // Zero threshold fires on every non-refractory update.
      issue(0, 3, 0, 2, 0, 0, 1'b0);
      issue(0, 4, 0, 2, 0, 0, 1'b0);
      // Interleave idx0/idx3, then back-to-back on one index.
      for (int i = 0; i < 8; i++) begin
         issue((i % 2 == 0) ? 0 : 3, $urandom_range(0, 60), 255, $urandom_range(0, 3), 0, 0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         issue(1, $urandom_range(0, 80), 200, 1, 1, 0, 1'b0);
      end
      // Input accepted together with clr_req, then sweep.
      issue(2, 90, 255, 0, 0, 0, 1'b1);
      for (int i = 0; i < N; i++) begin
         issue(i, 0, 255, 0, 0, 0, 1'b0);
      end

      // Randomized traffic with occasional sweeps and idle gaps.
      for (int i = 0; i < 400; i++) begin
         int thr;
         thr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, MAXV);
         issue($urandom_range(0, N - 1), $urandom_range(0, MAXV), thr,
               $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1),
               ($urandom_range(0, 40) == 0));
         if ($urandom_range(0, 4) == 0) idle(1);
      end

      // Async reset in the middle of a sweep.
      issue(3, 77, 255, 0, 0, 0, 1'b0);
      idle(2);
      bus.clr_req = 1'b1;
      @(posedge clk);
      #1;
      bus.clr_req = 1'b0;
      chk("sweep_started", int'(bus.in_ready), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midsweep_rst_out_valid", int'(bus.out_valid), 0);
      chk("midsweep_rst_out_state", int'(bus.out_state), 0);
      chk("midsweep_rst_in_ready", int'(bus.in_ready), 1);
      sb.delete();
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_release_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         issue(i, 1, 255, 0, 0, 0, 1'b0);
      end

      idle(3);
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
